// File: rtl/ccd_pkg.sv
// ccd_pkg: shared types and default timing for the linear-CCD line readout.
// Holds the sequencer state enum, default timing constants and sclk decode.
package ccd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SH   = 2'd1,
        PIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_NUM_PIX   = 2088;
    localparam int DEF_PIX_W     = 12;
    localparam int DEF_ADC_BITS  = 16;
    localparam int DEF_PIX_TICKS = 40;
    localparam int DEF_CS_TICKS  = 6;
    localparam int DEF_RS_T      = 12;
    localparam int DEF_CP_T      = 16;
    localparam int DEF_SH_TICKS  = 80;
    localparam int DEF_SH_T0     = 20;
    localparam int DEF_SH_T1     = 40;

    // True on the pixel-slot phases where adc_sclk is high.
    // Bit k is high at cs_ticks+2k and low at cs_ticks+2k+1.
    function automatic logic sclk_phase(
        input int ph,
        input int cs_ticks,
        input int adc_bits
    );
        int off;
        off = ph - cs_ticks;
        return (off >= 0) && (off < 2 * adc_bits) && (off[0] == 1'b0);
    endfunction

endpackage

// File: rtl/ccd_tick_gen.sv
// ccd_tick_gen: clock-enable tick generator for the CCD sequencer.
// Ports: clk_160M/rst (sync, active-high); clr latches div and clears the
// counter; tick is high in the cycle where count == latched div.
module ccd_tick_gen
    import ccd_pkg::*;
(
    input  logic       clk_160M,
    input  logic       rst,
    input  logic       clr,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] div_q;
    logic [7:0] cnt_q;

    assign tick = (cnt_q == div_q);

    always_ff @(posedge clk_160M) begin
        if (rst) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            div_q <= div;
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/ccd_line_readout.sv
// ccd_line_readout: linear-CCD line sequencer with serial-ADC capture.
// Ports: clk_160M, rst (sync active-high); start/abort/div/win_start/win_end
// from the scan controller; adc_sdo in; CCD clocks ccd_p1/p2/sh/rs/cp and
// adc_cs/adc_sclk out; pix_valid/pix_data/pix_idx to the packer; busy,
// line_done status. Optional macro CCD_TEST_PATTERN_EN adds test_mode,
// which replaces ADC data with a pixel-index ramp.
module ccd_line_readout
    import ccd_pkg::*;
#(
    parameter int NUM_PIX   = DEF_NUM_PIX,
    parameter int PIX_W     = DEF_PIX_W,
    parameter int ADC_BITS  = DEF_ADC_BITS,
    parameter int PIX_TICKS = DEF_PIX_TICKS,
    parameter int CS_TICKS  = DEF_CS_TICKS,
    parameter int RS_T      = DEF_RS_T,
    parameter int CP_T      = DEF_CP_T,
    parameter int SH_TICKS  = DEF_SH_TICKS,
    parameter int SH_T0     = DEF_SH_T0,
    parameter int SH_T1     = DEF_SH_T1
) (
    input  logic                clk_160M,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          div,
    input  logic [PIX_W-1:0]    win_start,
    input  logic [PIX_W-1:0]    win_end,
    input  logic                adc_sdo,
`ifdef CCD_TEST_PATTERN_EN
    input  logic                test_mode,
`endif
    output logic                ccd_p1,
    output logic                ccd_p2,
    output logic                ccd_sh,
    output logic                ccd_rs,
    output logic                ccd_cp,
    output logic                adc_cs,
    output logic                adc_sclk,
    output logic                pix_valid,
    output logic [ADC_BITS-1:0] pix_data,
    output logic [PIX_W-1:0]    pix_idx,
    output logic                busy,
    output logic                line_done
);

    localparam int PH_MAX = (SH_TICKS > PIX_TICKS) ? SH_TICKS : PIX_TICKS;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef logic [PH_W-1:0] ph_t;

    localparam ph_t SH_LAST  = ph_t'(SH_TICKS - 1);
    localparam ph_t PIX_LAST = ph_t'(PIX_TICKS - 1);
    localparam ph_t P1_FALL  = ph_t'(PIX_TICKS / 2);
    localparam ph_t SH_ON    = ph_t'(SH_T0);
    localparam ph_t SH_OFF   = ph_t'(SH_T1);
    localparam ph_t RS_A     = ph_t'(RS_T);
    localparam ph_t RS_B     = ph_t'(RS_T + 1);
    localparam ph_t CP_A     = ph_t'(CP_T);
    localparam ph_t CP_B     = ph_t'(CP_T + 1);
    localparam ph_t CS_END   = ph_t'(CS_TICKS);

    localparam logic [PIX_W-1:0] PIXEL_LAST = PIX_W'(NUM_PIX - 1);

    if ((CS_TICKS + 2 * ADC_BITS > PIX_TICKS) || (SH_T1 > SH_TICKS)) begin : g_bad_cfg
        $error("ccd_line_readout: ADC or SH timing does not fit its phase");
    end

    state_t              state_q;
    state_t              state_n;
    ph_t                 phase_q;
    ph_t                 phase_n;
    logic [PIX_W-1:0]    pixel_q;
    logic [PIX_W-1:0]    pixel_n;
    logic [PIX_W-1:0]    ws_q;
    logic [PIX_W-1:0]    we_q;
    logic [ADC_BITS-1:0] shift_q;
    logic [ADC_BITS-1:0] pix_src;

    logic tick;
    logic start_acc;
    logic slot_end;
    logic in_win;
    logic pv_n;

    logic p1_n;
    logic sh_n;
    logic rs_n;
    logic cp_n;
    logic cs_n;
    logic sclk_n;
    logic busy_n;
    logic done_n;

    // abort beats start when both arrive in IDLE
    assign start_acc = (state_q == IDLE) && start && !abort;
    assign slot_end  = (state_q == PIX) && tick && (phase_q == PIX_LAST);
    assign in_win    = (pixel_q >= ws_q) && (pixel_q <= we_q);
    assign pv_n      = slot_end && !abort && in_win;

    ccd_tick_gen u_tick (
        .clk_160M (clk_160M),
        .rst      (rst),
        .clr      (start_acc),
        .div      (div),
        .tick     (tick)
    );

`ifdef CCD_TEST_PATTERN_EN
    logic tm_q;

    always_ff @(posedge clk_160M) begin
        if (rst) begin
            tm_q <= 1'b0;
        end else if (start_acc) begin
            tm_q <= test_mode;
        end
    end

    assign pix_src = tm_q ? ADC_BITS'(pixel_q) : shift_q;
`else
    assign pix_src = shift_q;
`endif

    always_ff @(posedge clk_160M) begin
        if (rst) begin
            ws_q <= '0;
            we_q <= '0;
        end else if (start_acc) begin
            ws_q <= win_start;
            we_q <= win_end;
        end
    end

    always_ff @(posedge clk_160M) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            pixel_q <= '0;
        end else begin
            state_q <= state_n;
            phase_q <= phase_n;
            pixel_q <= pixel_n;
        end
    end

    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        pixel_n = pixel_q;
        unique case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_n = SH;
                    phase_n = '0;
                    pixel_n = '0;
                end
            end
            SH: begin
                if (abort) begin
                    state_n = IDLE;
                    phase_n = '0;
                end else if (tick) begin
                    if (phase_q == SH_LAST) begin
                        state_n = PIX;
                        phase_n = '0;
                    end else begin
                        phase_n = phase_q + 1'b1;
                    end
                end
            end
            PIX: begin
                if (abort) begin
                    state_n = IDLE;
                    phase_n = '0;
                end else if (tick) begin
                    if (phase_q == PIX_LAST) begin
                        phase_n = '0;
                        if (pixel_q == PIXEL_LAST) begin
                            state_n = DONE;
                        end else begin
                            pixel_n = pixel_q + 1'b1;
                        end
                    end else begin
                        phase_n = phase_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                phase_n = '0;
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
            end
        endcase
    end

    // Decode from the next state/phase so the registered pins change on
    // the same edge that advances the phase.
    always_comb begin
        p1_n   = 1'b1;
        sh_n   = 1'b0;
        rs_n   = 1'b0;
        cp_n   = 1'b0;
        cs_n   = 1'b0;
        sclk_n = 1'b0;
        busy_n = 1'b0;
        done_n = 1'b0;
        unique case (state_n)
            SH: begin
                busy_n = 1'b1;
                sh_n   = (phase_n >= SH_ON) && (phase_n < SH_OFF);
            end
            PIX: begin
                busy_n = 1'b1;
                p1_n   = (phase_n < P1_FALL);
                rs_n   = (phase_n == RS_A) || (phase_n == RS_B);
                cp_n   = (phase_n == CP_A) || (phase_n == CP_B);
                cs_n   = (phase_n < CS_END);
                sclk_n = sclk_phase(32'(phase_n), CS_TICKS, ADC_BITS);
            end
            DONE: begin
                done_n = 1'b1;
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
    end

    // The tick that leaves an sclk-high phase is the edge that drops
    // sclk; sdo is shifted in MSB first there.
    always_ff @(posedge clk_160M) begin
        if (rst) begin
            shift_q <= '0;
        end else if ((state_q == PIX) && tick &&
                     sclk_phase(32'(phase_q), CS_TICKS, ADC_BITS)) begin
            shift_q <= {shift_q[ADC_BITS-2:0], adc_sdo};
        end
    end

    always_ff @(posedge clk_160M) begin
        if (rst) begin
            ccd_p1    <= 1'b1;
            ccd_p2    <= 1'b0;
            ccd_sh    <= 1'b0;
            ccd_rs    <= 1'b0;
            ccd_cp    <= 1'b0;
            adc_cs    <= 1'b0;
            adc_sclk  <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_idx   <= '0;
            busy      <= 1'b0;
            line_done <= 1'b0;
        end else begin
            ccd_p1    <= p1_n;
            ccd_p2    <= ~p1_n;
            ccd_sh    <= sh_n;
            ccd_rs    <= rs_n;
            ccd_cp    <= cp_n;
            adc_cs    <= cs_n;
            adc_sclk  <= sclk_n;
            pix_valid <= pv_n;
            busy      <= busy_n;
            line_done <= done_n;
            if (pv_n) begin
                pix_data <= pix_src;
                pix_idx  <= pixel_q;
            end
        end
    end

endmodule

// File: tb/tb_ccd_line_readout.sv
// tb_ccd_line_readout: directed bench for ccd_line_readout (NUM_PIX=8).
// An ADC model drives adc_sdo with 16'hA5A0 + slot number of the line.
module tb_ccd_line_readout;

    localparam int NPIX = 8;
    localparam int PW   = 12;
    localparam int AB   = 16;

    logic          clk_160M = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    div = 8'd0;
    logic [PW-1:0] win_start = '0;
    logic [PW-1:0] win_end = 12'd7;
    logic          adc_sdo = 1'b0;

    logic          ccd_p1;
    logic          ccd_p2;
    logic          ccd_sh;
    logic          ccd_rs;
    logic          ccd_cp;
    logic          adc_cs;
    logic          adc_sclk;
    logic          pix_valid;
    logic [AB-1:0] pix_data;
    logic [PW-1:0] pix_idx;
    logic          busy;
    logic          line_done;

    ccd_line_readout #(
        .NUM_PIX (NPIX)
    ) dut (
        .clk_160M  (clk_160M),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .div       (div),
        .win_start (win_start),
        .win_end   (win_end),
        .adc_sdo   (adc_sdo),
`ifdef CCD_TEST_PATTERN_EN
        .test_mode (1'b0),
`endif
        .ccd_p1    (ccd_p1),
        .ccd_p2    (ccd_p2),
        .ccd_sh    (ccd_sh),
        .ccd_rs    (ccd_rs),
        .ccd_cp    (ccd_cp),
        .adc_cs    (adc_cs),
        .adc_sclk  (adc_sclk),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_idx   (pix_idx),
        .busy      (busy),
        .line_done (line_done)
    );

    always #3 clk_160M = ~clk_160M;

    int errors = 0;
    int checks = 0;

    // monitor state, written only by the monitor process
    int cyc = 0;
    int ld_n = 0;
    int ld_cyc = 0;
    int p12_bad = 0;
    int sh_run = 0;
    int sh_last = 0;
    int sclk_run = 0;
    int sclk_last = 0;
    int cs_run = 0;
    int cs_last = 0;
    int pv_idx[$];
    int pv_dat[$];
    int pv_cyc[$];
    int mcnt = 0;
    int mbit = 0;
    logic [15:0] mword = '0;
    logic cs_d = 1'b0;
    logic sclk_d = 1'b0;

    always @(negedge clk_160M) begin
        cyc++;
        if (pix_valid) begin
            pv_idx.push_back(int'(pix_idx));
            pv_dat.push_back(int'(pix_data));
            pv_cyc.push_back(cyc);
        end
        if (line_done) begin
            ld_n++;
            ld_cyc = cyc;
        end
        if (ccd_p2 !== ~ccd_p1) p12_bad++;
        if (ccd_sh) sh_run++;
        else if (sh_run != 0) begin sh_last = sh_run; sh_run = 0; end
        if (adc_sclk) sclk_run++;
        else if (sclk_run != 0) begin sclk_last = sclk_run; sclk_run = 0; end
        if (adc_cs) cs_run++;
        else if (cs_run != 0) begin cs_last = cs_run; cs_run = 0; end
        // ADC model: new word per conversion, next bit on each sclk rise
        if (start && !busy) mcnt = 0;
        if (adc_cs && !cs_d) begin
            mword = 16'hA5A0 + 16'(mcnt);
            mcnt++;
            mbit = 0;
        end
        if (adc_sclk && !sclk_d) begin
            adc_sdo = mword[15-mbit];
            mbit++;
        end
        cs_d = adc_cs;
        sclk_d = adc_sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_160M);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (line_done !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        chk("line_done_seen", 32'(line_done), 32'd1);
    endtask

    function automatic logic [31:0] pins();
        return 32'({ccd_p1, ccd_p2, ccd_sh, ccd_rs, ccd_cp,
                    adc_cs, adc_sclk, pix_valid, busy, line_done});
    endfunction

    localparam logic [31:0] IDLE_PINS = 32'h200;

    int b;
    int l0;
    int n;
    int t;

    initial begin
        // reset values
        step(2);
        chk("rst_pins", pins(), IDLE_PINS);
        chk("rst_data", 32'(pix_data), 32'd0);
        chk("rst_idx", 32'(pix_idx), 32'd0);
        rst = 1'b0;
        step(2);

        // start with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        chk("st_ab_busy", 32'(busy), 32'd0);
        step(3);
        chk("st_ab_pins", pins(), IDLE_PINS);

        // full line, div=0, window 0..7
        b = pv_idx.size();
        l0 = ld_n;
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done(1000);
        chk("t1_pv_with_done", 32'(pix_valid), 32'd1);
        chk("t1_busy_done", 32'(busy), 32'd0);
        step(1);
        chk("t1_ld_cnt", 32'(ld_n - l0), 32'd1);
        chk("t1_pv_cnt", 32'(pv_idx.size() - b), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_idx", 32'(pv_idx[b+i]), 32'(i));
            chk("t1_data", 32'(pv_dat[b+i]), 32'h0000A5A0 + 32'(i));
        end
        chk("t1_ld_cyc", 32'(ld_cyc), 32'(pv_cyc[b+7]));
        chk("t1_idle", pins(), IDLE_PINS);

        // div=3, config changed mid-line must be ignored
        div = 8'd3;
        b = pv_idx.size();
        pulse_start();
        div = 8'd0;
        win_start = 12'd5;
        wait_done(3000);
        step(1);
        chk("t2_pv_cnt", 32'(pv_idx.size() - b), 32'd8);
        chk("t2_slot", 32'(pv_cyc[b+1] - pv_cyc[b]), 32'd160);
        chk("t2_slot_last", 32'(pv_cyc[b+7] - pv_cyc[b+6]), 32'd160);
        chk("t2_sh_len", 32'(sh_last), 32'd80);
        chk("t2_sclk_len", 32'(sclk_last), 32'd4);
        chk("t2_cs_len", 32'(cs_last), 32'd24);
        chk("t2_data0", 32'(pv_dat[b]), 32'h0000A5A0);
        chk("t2_data7", 32'(pv_dat[b+7]), 32'h0000A5A7);

        // window 2..4
        win_start = 12'd2;
        win_end = 12'd4;
        b = pv_idx.size();
        pulse_start();
        wait_done(1000);
        step(1);
        chk("t3_pv_cnt", 32'(pv_idx.size() - b), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t3_idx", 32'(pv_idx[b+i]), 32'(i + 2));
            chk("t3_data", 32'(pv_dat[b+i]), 32'h0000A5A2 + 32'(i));
        end

        // window 5..1: empty
        win_start = 12'd5;
        win_end = 12'd1;
        b = pv_idx.size();
        l0 = ld_n;
        pulse_start();
        wait_done(1000);
        step(1);
        chk("t4_pv_cnt", 32'(pv_idx.size() - b), 32'd0);
        chk("t4_ld_cnt", 32'(ld_n - l0), 32'd1);

        // abort at pixel 3, phase 10
        win_start = 12'd0;
        win_end = 12'd7;
        b = pv_idx.size();
        l0 = ld_n;
        pulse_start();
        n = 0;
        t = 0;
        while (n < 3 && t < 2000) begin
            step(1);
            t++;
            if (pix_valid) n++;
        end
        chk("t5_reach_pix3", 32'(n), 32'd3);
        step(10);
        chk("t5_pre_sclk", 32'(adc_sclk), 32'd1);
        chk("t5_pre_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t5_abort_pins", pins(), IDLE_PINS);
        step(5);
        chk("t5_no_ld", 32'(ld_n - l0), 32'd0);
        chk("t5_pv_cnt", 32'(pv_idx.size() - b), 32'd3);
        b = pv_idx.size();
        pulse_start();
        wait_done(1000);
        step(1);
        chk("t5_rerun_cnt", 32'(pv_idx.size() - b), 32'd8);
        chk("t5_rerun_d0", 32'(pv_dat[b]), 32'h0000A5A0);
        chk("t5_rerun_d7", 32'(pv_dat[b+7]), 32'h0000A5A7);

        // reset in mid-SH
        l0 = ld_n;
        pulse_start();
        step(29);
        chk("t6_sh_high", 32'(ccd_sh), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6_rst_pins", pins(), IDLE_PINS);
        chk("t6_rst_data", 32'(pix_data), 32'd0);
        chk("t6_rst_idx", 32'(pix_idx), 32'd0);
        step(3);
        chk("t6_stay_idle", pins(), IDLE_PINS);
        chk("t6_no_ld", 32'(ld_n - l0), 32'd0);

        // start during busy is ignored
        b = pv_idx.size();
        l0 = ld_n;
        pulse_start();
        step(200);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(1000);
        step(1);
        chk("t6_pv_cnt", 32'(pv_idx.size() - b), 32'd8);
        chk("t6_ld_cnt", 32'(ld_n - l0), 32'd1);
        chk("t6_last_idx", 32'(pv_idx[b+7]), 32'd7);

        chk("p2_is_not_p1", 32'(p12_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
